// File: rtl/mem_port_arbiter.sv
// Burst arbiter for the shared single-port image/filter memory: grants whole bursts,
// generates beat addresses and routes read data back. Define MEM_ARB_FIXED_PRIO_EN for fixed priority.
module mem_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 8,
  parameter int MEM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        wready,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nx;

  logic [IDX_W-1:0]  win, pick;
  logic              found;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q, beat;
  logic              we_q;
  logic              in_burst, rd_beat;

  logic [MEM_LAT:1]  vld_pipe;
  logic [IDX_W-1:0]  tag_pipe [1:MEM_LAT];

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest requesting index is the last assignment.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req[i]) begin
        pick  = IDX_W'(i);
        found = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] ptr;

  // Scan offsets from ptr downward so the smallest offset from ptr wins.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    found = 1'b0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (req[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (state == IDLE && found)
      ptr <= (pick == IDX_W'(NUM_REQ-1)) ? '0 : pick + 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = BURST;
      BURST:   if (beat == len_q) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win    <= '0;
      addr_q <= '0;
      len_q  <= '0;
      we_q   <= 1'b0;
      beat   <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        win    <= pick;
        addr_q <= req_addr[int'(pick)*ADDR_W +: ADDR_W];
        len_q  <= req_len[int'(pick)*LEN_W +: LEN_W];
        we_q   <= req_we[pick];
        beat   <= '0;
      end
    end else begin
      addr_q <= addr_q + 1'b1;
      beat   <= beat + 1'b1;
    end
  end

  assign in_burst  = (state == BURST);
  assign rd_beat   = in_burst && !we_q;
  assign mem_en    = in_burst;
  assign mem_we    = in_burst && we_q;
  assign mem_addr  = in_burst ? addr_q : '0;
  assign mem_wdata = mem_we ? wdata[int'(win)*DATA_W +: DATA_W] : '0;

  // Read tags ride alongside the memory latency so rvalid lines up with mem_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 1; i <= MEM_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      vld_pipe[1] <= rd_beat;
      tag_pipe[1] <= win;
      for (int i = 2; i <= MEM_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  always_comb begin
    gnt    = '0;
    wready = '0;
    rvalid = '0;
    if (in_burst && beat == '0) gnt[win] = 1'b1;
    if (mem_we) wready[win] = 1'b1;
    if (vld_pipe[MEM_LAT]) rvalid[tag_pipe[MEM_LAT]] = 1'b1;
  end

  assign rdata = vld_pipe[MEM_LAT] ? mem_rdata : '0;
  assign busy  = in_burst || (|vld_pipe);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3,
// sharing requester stimulus; each has its own memory model.
module tb_mem_port_arbiter;
  logic        clk, rst_n;
  logic [2:0]  req, req_we;
  logic [47:0] req_addr;
  logic [23:0] req_len;
  logic [95:0] wdata;

  logic [2:0]  gnt1, wready1, rvalid1, gnt3, wready3, rvalid3;
  logic [31:0] rdata1, rdata3, mem_wdata1, mem_wdata3, mem_rdata1, mem_rdata3;
  logic [15:0] mem_addr1, mem_addr3;
  logic        busy1, busy3, mem_en1, mem_en3, mem_we1, mem_we3;

  mem_port_arbiter #(.NUM_REQ(3), .ADDR_W(16), .DATA_W(32), .LEN_W(8), .MEM_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_len(req_len), .wdata(wdata), .gnt(gnt1), .wready(wready1), .rvalid(rvalid1),
    .rdata(rdata1), .busy(busy1), .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1));

  mem_port_arbiter #(.NUM_REQ(3), .ADDR_W(16), .DATA_W(32), .LEN_W(8), .MEM_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_len(req_len), .wdata(wdata), .gnt(gnt3), .wready(wready3), .rvalid(rvalid3),
    .rdata(rdata3), .busy(busy3), .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rom(input logic [15:0] a);
    return {~a, a};
  endfunction

  logic [31:0] m3 [0:2];
  always @(posedge clk) begin
    mem_rdata1 <= (mem_en1 && !mem_we1) ? rom(mem_addr1) : 32'h0;
    m3[0]      <= (mem_en3 && !mem_we3) ? rom(mem_addr3) : 32'h0;
    m3[1]      <= m3[0];
    m3[2]      <= m3[1];
  end
  assign mem_rdata3 = m3[2];

  typedef struct { int r; logic we; logic [15:0] a; logic [31:0] d; logic first; } beat_t;
  typedef struct { int r; logic [31:0] d; } rd_t;
  beat_t exp_beat[$];
  rd_t   exp_rd1[$], exp_rd3[$];
  int    bc1[$], bc3[$];
  int    n_cmp = 0, n_err = 0;

  task automatic push_burst(input int r, input logic we, input logic [15:0] a,
                            input int nbeat, input logic [31:0] wd0);
    for (int k = 0; k < nbeat; k++) begin
      beat_t b;
      rd_t   q;
      b.r = r; b.we = we; b.a = a + 16'(k); b.d = wd0 + 32'(k); b.first = (k == 0);
      exp_beat.push_back(b);
      if (!we) begin
        q.r = r; q.d = rom(b.a);
        exp_rd1.push_back(q);
        exp_rd3.push_back(q);
      end
    end
  endtask

  task automatic start_req(input int r, input logic we, input logic [15:0] a,
                           input logic [7:0] len, input logic [31:0] wd);
    req_addr[r*16 +: 16] = a;
    req_len[r*8 +: 8]    = len;
    req_we[r]            = we;
    wdata[r*32 +: 32]    = wd;
    req[r]               = 1'b1;
  endtask

  task automatic wait_gnt(input int r, output int gc);
    gc = -1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (gnt1[r]) begin
        gc = cyc;
        break;
      end
    end
    if (gc < 0) begin
      n_cmp++; n_err++;
      $display("FAIL gnt_timeout r=%0d: no grant within 30 cycles", r);
    end
  endtask

  // Beat, grant and read-return scoreboard, checked mid-cycle.
  beat_t mb;
  rd_t   mq;
  int    mc;
  always @(negedge clk) begin
    if (!rst_n) begin
      bc1.delete();
      bc3.delete();
    end else begin
      n_cmp++;
      if (mem_en1) begin
        if (exp_beat.size() == 0) begin
          n_err++;
          $display("FAIL beat_unexpected: got addr=%h we=%b, want no beat", mem_addr1, mem_we1);
        end else begin
          mb = exp_beat.pop_front();
          if (mem_we1 !== mb.we || mem_addr1 !== mb.a ||
              gnt1 !== (mb.first ? 3'(1 << mb.r) : 3'b0) ||
              wready1 !== (mb.we ? 3'(1 << mb.r) : 3'b0) ||
              (mb.we && mem_wdata1 !== mb.d)) begin
            n_err++;
            $display("FAIL beat: got we=%b addr=%h gnt=%b wready=%b wdata=%h, want we=%b addr=%h r=%0d first=%b wdata=%h",
                     mem_we1, mem_addr1, gnt1, wready1, mem_wdata1, mb.we, mb.a, mb.r, mb.first, mb.d);
          end
          if (!mb.we) begin
            bc1.push_back(cyc);
            bc3.push_back(cyc);
          end
        end
      end else if (gnt1 !== 3'b0 || wready1 !== 3'b0 || mem_we1 !== 1'b0) begin
        n_err++;
        $display("FAIL idle_outputs: got gnt=%b wready=%b mem_we=%b, want all 0", gnt1, wready1, mem_we1);
      end
      if (rvalid1 !== 3'b0) begin
        n_cmp++;
        if (exp_rd1.size() == 0 || bc1.size() == 0) begin
          n_err++;
          $display("FAIL rvalid1_unexpected: got rvalid=%b, want 000", rvalid1);
        end else begin
          mq = exp_rd1.pop_front();
          mc = bc1.pop_front();
          if (rvalid1 !== 3'(1 << mq.r) || rdata1 !== mq.d || cyc - mc != 1) begin
            n_err++;
            $display("FAIL rvalid1: got rvalid=%b rdata=%h lat=%0d, want rvalid=%b rdata=%h lat=1",
                     rvalid1, rdata1, cyc - mc, 3'(1 << mq.r), mq.d);
          end
        end
      end
      if (rvalid3 !== 3'b0) begin
        n_cmp++;
        if (exp_rd3.size() == 0 || bc3.size() == 0) begin
          n_err++;
          $display("FAIL rvalid3_unexpected: got rvalid=%b, want 000", rvalid3);
        end else begin
          mq = exp_rd3.pop_front();
          mc = bc3.pop_front();
          if (rvalid3 !== 3'(1 << mq.r) || rdata3 !== mq.d || cyc - mc != 3) begin
            n_err++;
            $display("FAIL rvalid3: got rvalid=%b rdata=%h lat=%0d, want rvalid=%b rdata=%h lat=3",
                     rvalid3, rdata3, cyc - mc, 3'(1 << mq.r), mq.d);
          end
        end
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({gnt1, wready1, rvalid1, rdata1, busy1, mem_en1, mem_we1, mem_addr1, mem_wdata1,
         gnt3, wready3, rvalid3, rdata3, busy3, mem_en3, mem_we3, mem_addr3, mem_wdata3} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got gnt=%b busy=%b mem_en=%b addr=%h, want all 0",
               gnt1, busy1, mem_en1, mem_addr1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy1 !== 1'b0 || mem_en1 !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: got busy=%b mem_en=%b, want 0 0", busy1, mem_en1);
    end
  endtask

  task automatic test_single_read();
    int g, cnt;
    push_burst(1, 1'b0, 16'h0040, 4, 32'h0);
    start_req(1, 1'b0, 16'h0040, 8'd3, 32'h0);
    wait_gnt(1, g);
    @(posedge clk); #1 req[1] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rvalid1[1]) cnt++;
    end
    n_cmp++;
    if (cnt != 4 || busy1 !== 1'b0) begin
      n_err++;
      $display("FAIL single_read: got rvalid_cycles=%0d busy=%b, want 4 0", cnt, busy1);
    end
  endtask

  task automatic test_write();
    int g, cnt;
    push_burst(2, 1'b1, 16'h0100, 3, 32'hA5A5_0000);
    start_req(2, 1'b1, 16'h0100, 8'd2, 32'hA5A5_0000);
    wait_gnt(2, g);
    cnt = wready1[2] ? 1 : 0;
    for (int k = 1; k < 6; k++) begin
      @(posedge clk);
      #1;
      req[2] = 1'b0;
      wdata[64 +: 32] = 32'hA5A5_0000 + 32'(k);
      @(negedge clk);
      if (wready1[2]) cnt++;
    end
    req_we[2] = 1'b0;
    n_cmp++;
    if (cnt != 3) begin
      n_err++;
      $display("FAIL write_wready: got %0d cycles, want 3", cnt);
    end
  endtask

  task automatic test_wrap_latency();
    int g;
    push_burst(2, 1'b0, 16'hFFFF, 2, 32'h0);
    start_req(2, 1'b0, 16'hFFFF, 8'd1, 32'h0);
    wait_gnt(2, g);
    @(posedge clk); #1 req[2] = 1'b0;
    while (cyc < g + 2) @(negedge clk);
    n_cmp++;
    if (rvalid3 !== 3'b000 || busy3 !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_early: got rvalid3=%b busy3=%b, want 000 1", rvalid3, busy3);
    end
    while (cyc < g + 4) @(negedge clk);
    n_cmp++;
    if (rvalid3 !== 3'b100 || busy3 !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_last_rvalid: got rvalid3=%b busy3=%b, want 100 1", rvalid3, busy3);
    end
    @(negedge clk);
    n_cmp++;
    if (busy3 !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_busy_fall: got busy3=%b, want 0", busy3);
    end
  endtask

  task automatic test_late_request();
    int g1, g0;
    push_burst(1, 1'b0, 16'h0500, 4, 32'h0);
    push_burst(0, 1'b0, 16'h0600, 2, 32'h0);
    start_req(1, 1'b0, 16'h0500, 8'd3, 32'h0);
    wait_gnt(1, g1);
    @(posedge clk); #1;
    req[1] = 1'b0;
    start_req(0, 1'b0, 16'h0600, 8'd1, 32'h0);
    wait_gnt(0, g0);
    @(posedge clk); #1 req[0] = 1'b0;
    n_cmp++;
    if (g0 - g1 != 5) begin
      n_err++;
      $display("FAIL late_request: got grant gap=%0d, want 5", g0 - g1);
    end
  endtask

  task automatic test_contention();
    int prev, got, exp_r;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_r = 0;
`else
      exp_r = k % 3;
`endif
      push_burst(exp_r, 1'b0, 16'h0200 + 16'(exp_r), 1, 32'h0);
    end
    for (int r = 0; r < 3; r++) start_req(r, 1'b0, 16'h0200 + 16'(r), 8'd0, 32'h0);
    prev = -1;
    for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_r = 0;
`else
      exp_r = k % 3;
`endif
      got = -1;
      for (int t = 0; t < 10 && got < 0; t++) begin
        @(negedge clk);
        if (gnt1 !== 3'b0) got = cyc;
      end
      n_cmp++;
      if (got < 0 || gnt1 !== 3'(1 << exp_r) || (prev >= 0 && got - prev != 2)) begin
        n_err++;
        $display("FAIL contention_%0d: got gnt=%b gap=%0d, want gnt=%b gap=2",
                 k, gnt1, got - prev, 3'(1 << exp_r));
      end
      prev = got;
    end
    req = 3'b000;
  endtask

  task automatic test_reset_mid_burst();
    int g, got;
    beat_t b;
    rd_t   q;
    for (int k = 0; k < 2; k++) begin
      b.r = 1; b.we = 1'b0; b.a = 16'h0300 + 16'(k); b.d = 32'h0; b.first = (k == 0);
      exp_beat.push_back(b);
    end
    q.r = 1; q.d = rom(16'h0300);
    exp_rd1.push_back(q);
    start_req(1, 1'b0, 16'h0300, 8'd7, 32'h0);
    wait_gnt(1, g);
    @(posedge clk); #1 req[1] = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({gnt1, rvalid1, rdata1, busy1, mem_en1, mem_addr1, gnt3, rvalid3, busy3, mem_en3} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_burst: got mem_en=%b addr=%h rvalid=%b busy=%b, want all 0",
               mem_en1, mem_addr1, rvalid1, busy1);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    push_burst(0, 1'b0, 16'h0700, 1, 32'h0);
    @(posedge clk); #1;
    for (int r = 0; r < 3; r++) start_req(r, 1'b0, 16'h0700 + 16'(r), 8'd0, 32'h0);
    got = -1;
    for (int t = 0; t < 10 && got < 0; t++) begin
      @(negedge clk);
      if (gnt1 !== 3'b0) got = cyc;
    end
    req = 3'b000;
    n_cmp++;
    if (got < 0 || gnt1 !== 3'b001) begin
      n_err++;
      $display("FAIL first_grant_after_reset: got gnt=%b, want 001", gnt1);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_we = '0; req_addr = '0; req_len = '0; wdata = '0;
    test_reset();
    test_single_read();
    repeat (4) @(posedge clk);
    test_write();
    repeat (4) @(posedge clk);
    test_wrap_latency();
    repeat (4) @(posedge clk);
    test_late_request();
    repeat (8) @(posedge clk);
    test_contention();
    repeat (8) @(posedge clk);
    test_reset_mid_burst();
    repeat (10) @(negedge clk);
    n_cmp++;
    if (exp_beat.size() != 0 || exp_rd1.size() != 0 || exp_rd3.size() != 0) begin
      n_err++;
      $display("FAIL leftover_expected: got beats=%0d rd1=%0d rd3=%0d pending, want 0 0 0",
               exp_beat.size(), exp_rd1.size(), exp_rd3.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
